// File: rtl/envelope_vca.sv
// rtl/envelope_vca.sv - envelope-controlled amplifier: signed sample times unsigned gain, shift-add, saturated
module envelope_vca #(
  parameter int SAMPLE_W  = 16,
  parameter int ENV_W     = 31,
  parameter int FRAC_BITS = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic [ENV_W-1:0]    envelope,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                busy
);

  localparam int ACC_W = SAMPLE_W + ENV_W;
  localparam int CNT_W = (ENV_W > 1) ? $clog2(ENV_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ENV_W - 1);
  localparam logic [ACC_W-1:0] POS_LIM = ACC_W'((64'd1 << (SAMPLE_W - 1)) - 64'd1);
  localparam logic [ACC_W-1:0] NEG_LIM = ACC_W'(64'd1 << (SAMPLE_W - 1));
  localparam logic [SAMPLE_W-1:0] POS_SAT = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [SAMPLE_W-1:0] NEG_SAT = {1'b1, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t              state;
  logic                sign_q;
  logic [SAMPLE_W-1:0] mag_q;
  logic [ENV_W-1:0]    env_q;
  logic [ACC_W-1:0]    acc;
  logic [CNT_W-1:0]    cnt;

  logic [SAMPLE_W-1:0] in_mag;
  logic [ACC_W-1:0]    mag_ext;
  logic [ACC_W-1:0]    q;
  logic [SAMPLE_W-1:0] result;

  // Two's-complement absolute value; the most negative sample maps cleanly onto 2^(SAMPLE_W-1).
  always_comb begin
    in_mag = sample_in;
    if (sample_in[SAMPLE_W-1]) begin
      in_mag = ~sample_in + SAMPLE_W'(1);
    end
  end

  assign mag_ext = ACC_W'(mag_q);
  assign q       = acc >> FRAC_BITS;

  // Truncating the magnitude before re-applying the sign rounds toward zero; 0 never becomes -0.
  always_comb begin
    result = '0;
    if (sign_q) begin
      result = (q > NEG_LIM) ? NEG_SAT : (SAMPLE_W'(0) - q[SAMPLE_W-1:0]);
    end else begin
      result = (q > POS_LIM) ? POS_SAT : q[SAMPLE_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      sample_out <= '0;
      busy       <= 1'b0;
      sign_q     <= 1'b0;
      mag_q      <= '0;
      env_q      <= '0;
      acc        <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_q   <= sample_in[SAMPLE_W-1];
            mag_q    <= in_mag;
            env_q    <= envelope;
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= MUL;
          end
        end
        MUL: begin
          if (env_q[cnt]) begin
            acc <= acc + (mag_ext << cnt);
          end
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            state <= NORM;
          end
        end
        NORM: begin
          sample_out <= result;
          out_valid  <= 1'b1;
          state      <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_envelope_vca.sv
// tb/tb_envelope_vca.sv - self-checking bench for envelope_vca
module tb_envelope_vca;
  localparam int SW = 16;
  localparam int EW = 31;
  localparam int FB = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] sample_in;
  logic [EW-1:0] envelope;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] sample_out;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  envelope_vca #(.SAMPLE_W(SW), .ENV_W(EW), .FRAC_BITS(FB)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .sample_in(sample_in), .envelope(envelope),
    .out_valid(out_valid), .out_ready(out_ready),
    .sample_out(sample_out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          smp;
    longint      env;
    int          exp;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: exact product, divide by unity gain (truncates toward zero), clamp to sample range.
  function automatic longint model(input longint s, input longint e);
    longint p, q;
    p = s * e;
    q = p / (64'sd1 <<< FB);
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return q;
  endfunction

  task automatic do_op(input string name, input int s, input longint e, input longint exp);
    int w;
    int lat;
    w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    if (!in_ready) check({name, "_in_ready_wait"}, 0, 1);
    sample_in = SW'(s);
    envelope  = EW'(e);
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!out_valid && lat < 100);
    check({name, "_latency"}, lat, 32);
    check({name, "_value"}, longint'($signed(sample_out)), exp);
    @(posedge clk); #1;
    check({name, "_ov_drop"}, out_valid, 0);
    check({name, "_in_ready_back"}, in_ready, 1);
  endtask

  vec_t vecs[$];

  initial begin
    int lat;
    int s;
    longint e;
    logic [SW-1:0] held;
    bit saw_valid;

    vecs.push_back('{"unity",      1000,   64'd1 << 20,        1000});
    vecs.push_back('{"neg_half",   -3,     64'd1 << 19,        -1});
    vecs.push_back('{"pos_half",   3,      64'd1 << 19,        1});
    vecs.push_back('{"min_half",   -32768, 64'd1 << 19,        -16384});
    vecs.push_back('{"sat_pos",    20000,  64'd1 << 21,        32767});
    vecs.push_back('{"sat_min",    -32768, 64'd1 << 21,        -32768});
    vecs.push_back('{"sat_negmax", -20000, (64'd1 << 31) - 1,  -32768});
    vecs.push_back('{"zero_env",   -12345, 0,                  0});

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    sample_in = '0; envelope = '0;
    #22;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sample_out", sample_out, 0);
    check("rst_busy", busy, 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) do_op(vecs[i].name, vecs[i].smp, vecs[i].env, vecs[i].exp);

    for (longint ev = 0; ev <= (64'd1 << 20); ev += (64'd1 << 16))
      do_op("sweep", 16384, ev, ev >> 6);

    for (int i = 0; i < 40; i++) begin
      s = int'($signed(16'($urandom)));
      case (i % 4)
        0: e = longint'($urandom_range(0, 2**21));
        1: e = longint'($urandom) & ((64'd1 << 31) - 1);
        2: e = longint'($urandom_range(0, 2**20));
        default: e = longint'($urandom_range(2**19, 2**22));
      endcase
      do_op("random", s, e, model(s, e));
    end

    // Backpressure with operand churn during MUL
    out_ready = 1'b0;
    sample_in = SW'(7000); envelope = EW'((1 << 20) + (1 << 19)); in_valid = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    do begin
      in_valid = 1'($urandom); sample_in = SW'($urandom); envelope = EW'($urandom);
      @(posedge clk); #1; lat++;
    end while (!out_valid && lat < 100);
    in_valid = 1'b0;
    check("bp_latency", lat, 32);
    check("bp_value", longint'($signed(sample_out)), 10500);
    held = sample_out;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_data", sample_out, held);
      check("bp_hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);
    saw_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid || busy) saw_valid = 1'b1;
    end
    check("bp_single_transfer", saw_valid, 0);

    // Asynchronous reset while cnt=15
    sample_in = SW'(1234); envelope = EW'(1 << 20); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_sample_out", sample_out, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    saw_valid = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    check("mid_rst_no_output", saw_valid, 0);
    do_op("post_reset", 500, 64'd1 << 20, 500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/envelope_vca.md
Name: envelope_vca

Overview:
- Voltage-controlled-amplifier stage sitting directly downstream of the ADSR envelope generator.
- Multiplies each signed oscillator sample by the envelope generator's 31-bit amplitude output (cur_amplitude) and emits the scaled, saturated sample to the mixer/audio output path.
- Uses a sequential shift-add multiplier, one envelope bit per clock, behind valid/ready handshakes on both sides. Audio sample rate is far below the clock rate, so throughput is not a constraint.

Parameters:
SAMPLE_W, 16, width of signed input/output samples (two's complement)
ENV_W, 31, width of unsigned envelope gain input
FRAC_BITS, 20, fractional bits of gain; gain value 2^FRAC_BITS equals unity (1.0)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  sample_in/envelope valid this cycle
in_ready  output  1  block can accept a new sample
sample_in  input  SAMPLE_W  signed oscillator sample
envelope  input  ENV_W  unsigned gain from envelope generator
out_valid  output  1  sample_out valid
out_ready  input  1  downstream accepts sample_out
sample_out  output  SAMPLE_W  signed scaled, saturated sample
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, active-high):
  - state=IDLE, in_ready=1, out_valid=0, sample_out=0, busy=0.
  - Clears the accumulator, bit counter and latched operands.
  - Reset asserted mid-operation aborts the operation; no output is produced for the aborted sample.
- FSM states:
  - IDLE: in_ready=1. On in_valid at a clock edge (accept), latch:
    - sign = sample_in MSB;
    - mag = |sample_in| as a SAMPLE_W-bit unsigned value (-2^(SAMPLE_W-1) maps to 2^(SAMPLE_W-1), no overflow);
    - env_q = envelope snapshot.
    - Clear the acc (SAMPLE_W+ENV_W bits), set cnt=0, then go to MUL.
    - in_ready is 0 in every other state.
  - MUL: each cycle, if env_q[cnt]=1 then acc += mag << cnt; cnt++.
    - After the cycle with cnt=ENV_W-1, go to NORM. Exactly ENV_W cycles in MUL.
    - Changes on envelope/sample_in after accept have no effect.
  - NORM: one cycle.
    - q = acc >> FRAC_BITS (truncation of magnitude, i.e. round toward zero on the signed result).
    - If sign=0: result = min(q, 2^(SAMPLE_W-1)-1).
    - If sign=1: result = -min(q, 2^(SAMPLE_W-1)).
    - Register result into sample_out, set out_valid=1, go to OUT.
  - OUT: hold sample_out and out_valid stable while out_ready=0.
    - On a clock edge with out_ready=1: out_valid<=0, go to IDLE.
    - No accept occurs in the same edge, so the minimum issue interval is ENV_W+3 cycles.
- Latency: out_valid rises ENV_W+1 clock edges after the accepting edge (32 edges with defaults).
- sample_out keeps its last value after the handshake until the next NORM; it is meaningful only while out_valid=1.
- Arithmetic:
  - acc never overflows: max product is 2^(SAMPLE_W-1)·(2^ENV_W-1) < 2^(SAMPLE_W+ENV_W).
  - Gain above unity amplifies, with saturation.
  - envelope=0 yields sample_out=0 (positive zero, never negative zero).
- Simultaneous events:
  - in_valid while not IDLE: ignored; upstream holds it per the handshake.
  - out_ready high while out_valid=0: no effect.
- busy = (state != IDLE).

Test Plan:
- Unity gain: sample_in=1000, envelope=2^20, out_ready=1 -> sample_out=1000, out_valid high exactly 32 edges after accept, one cycle wide; then in_ready=1.
- Negative truncation: sample_in=-3, envelope=2^19 (0.5) -> sample_out=-1; sample_in=3, same gain -> 1; sample_in=-32768, envelope=2^19 -> -16384.
- Saturation: sample_in=20000, envelope=2^21 -> 32767; sample_in=-32768, envelope=2^21 -> -32768; sample_in=-20000, envelope=2^31-1 -> -32768.
- Zero/release tail: envelope=0 with sample_in=-12345 -> sample_out=0. Then sweep envelope values 0..2^20 step 2^16 with sample_in=16384 -> sample_out=envelope>>6 each time.
- Backpressure and operand isolation:
  - out_ready=0 for 10 cycles after out_valid -> sample_out/out_valid held stable, in_ready=0 throughout.
  - Toggling in_valid/sample_in/envelope during MUL does not change the result.
  - Releasing out_ready completes one transfer only.
- Reset mid-operation: assert reset asynchronously at cnt=15 -> immediately out_valid=0, sample_out=0, in_ready=1, busy=0. After deassert, a new sample (500, gain 2^20) returns 500 with full 32-edge latency.
